pong_score_ctrl: RTL

- Game-flow controller for the Pong score path.
- Turns raw per-player scoring strobes from the ball/collision logic into BCD scores for the two active digits of the seven_seg display.
- Sequences play: serve wait, rally, post-point pause, game over.
- Gates the ball engine through ball_enable and blinks the winner's digit at game end.

---
 rtl/pong_score_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pong_score_ctrl.sv
// Pong game-flow controller: edge-detects serve/score strobes, keeps BCD scores,
// sequences IDLE/PLAY/PAUSE/GAMEOVER and blinks the winner's digit at game end.
module pong_score_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_CYCLES = 25000000,
  parameter int BLINK_BITS   = 23
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_scored,
  input  logic       p2_scored,
  output logic [3:0] first,
  output logic [3:0] second,
  output logic       ball_enable,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);

  localparam int PW = (PAUSE_CYCLES > 2) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [PW-1:0]         PAUSE_LOAD = PW'(PAUSE_CYCLES - 1);
  localparam logic [PW-1:0]         PAUSE_ONE  = PW'(1);
  localparam logic [BLINK_BITS-1:0] BLINK_ONE  = BLINK_BITS'(1);
  localparam logic [3:0]            WIN4       = 4'(WIN_SCORE);
  localparam logic [3:0]            BLANK      = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    PAUSE    = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  state_t                state;
  logic [3:0]            score1;
  logic [3:0]            score2;
  logic [PW-1:0]         pause_cnt;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic [BLINK_BITS-1:0] blink_nxt;
  logic                  prev_start;
  logic                  prev_p1;
  logic                  prev_p2;

  logic       start_ev;
  logic       p1_ev;
  logic       p2_ev;
  logic       blink_off;
  logic [3:0] score1_inc;
  logic [3:0] score2_inc;

  // A held level yields one event: the history regs update in every state.
  assign start_ev   = start & ~prev_start;
  assign p1_ev      = p1_scored & ~prev_p1;
  assign p2_ev      = p2_scored & ~prev_p2;
  assign score1_inc = score1 + 4'd1;
  assign score2_inc = score2 + 4'd1;

  // Display registers follow the counter value being written this cycle.
  assign blink_nxt  = blink_cnt + BLINK_ONE;
  assign blink_off  = blink_nxt[BLINK_BITS-1];

  // NOTE: every register here is assigned non-blocking so that all branches
  // read the pre-edge values of state, scores and counters consistently.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      score1      <= 4'd0;
      score2      <= 4'd0;
      first       <= 4'd0;
      second      <= 4'd0;
      ball_enable <= 1'b0;
      serve_dir   <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      pause_cnt   <= '0;
      blink_cnt   <= '0;
      prev_start  <= 1'b0;
      prev_p1     <= 1'b0;
      prev_p2     <= 1'b0;
    end else begin
      prev_start <= start;
      prev_p1    <= p1_scored;
      prev_p2    <= p2_scored;

      case (state)
        IDLE: begin
          ball_enable <= 1'b0;
          if (start_ev) begin
            state       <= PLAY;
            ball_enable <= 1'b1;
          end
        end

        PLAY: begin
          if (p1_ev && p2_ev) begin
            // Simultaneous points are a draw: no score, just re-serve.
            state       <= PAUSE;
            pause_cnt   <= PAUSE_LOAD;
            ball_enable <= 1'b0;
          end else if (p1_ev) begin
            score1      <= score1_inc;
            first       <= score1_inc;
            serve_dir   <= 1'b1;
            ball_enable <= 1'b0;
            if (score1_inc == WIN4) begin
              state     <= GAMEOVER;
              game_over <= 1'b1;
              winner    <= 1'b0;
            end else begin
              state     <= PAUSE;
              pause_cnt <= PAUSE_LOAD;
            end
          end else if (p2_ev) begin
            score2      <= score2_inc;
            second      <= score2_inc;
            serve_dir   <= 1'b0;
            ball_enable <= 1'b0;
            if (score2_inc == WIN4) begin
              state     <= GAMEOVER;
              game_over <= 1'b1;
              winner    <= 1'b1;
            end else begin
              state     <= PAUSE;
              pause_cnt <= PAUSE_LOAD;
            end
          end else begin
            ball_enable <= 1'b1;
          end
        end

        PAUSE: begin
          if (pause_cnt == '0) begin
            state       <= PLAY;
            ball_enable <= 1'b1;
          end else begin
            pause_cnt   <= pause_cnt - PAUSE_ONE;
            ball_enable <= 1'b0;
          end
        end

        GAMEOVER: begin
          ball_enable <= 1'b0;
          if (start_ev) begin
            state     <= IDLE;
            score1    <= 4'd0;
            score2    <= 4'd0;
            first     <= 4'd0;
            second    <= 4'd0;
            game_over <= 1'b0;
            blink_cnt <= '0;
          end else begin
            blink_cnt <= blink_nxt;
            first     <= (!winner && blink_off) ? BLANK : score1;
            second    <= ( winner && blink_off) ? BLANK : score2;
          end
        end

        default: begin
          state       <= IDLE;
          ball_enable <= 1'b0;
          game_over   <= 1'b0;
        end
      endcase
    end
  end

endmodule
